// File: rtl/phase_sequencer.sv
// Five-phase instruction sequencer (fetch/decode/execute/memory/writeback) with per-phase stalls.
// Optional interrupt trap entry at writeback completion, enabled by defining RW_PHASE_IRQ_EN.
module phase_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            stall_fetch,
  input  logic            stall_decode,
  input  logic            stall_execute,
  input  logic            stall_memory,
  input  logic            stall_writeback,
  input  logic            irq_req,
  input  logic            irq_enable,
  output logic            phase_fetch,
  output logic            phase_decode,
  output logic            phase_execute,
  output logic            phase_memory,
  output logic            phase_writeback,
  output logic            irq_ack,
  output logic            busy,
  output logic [XLEN-1:0] retire_count
);

`ifdef RW_PHASE_IRQ_EN
  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK
  } state_t;
`endif

  state_t state;
  state_t state_nxt;
  logic   wb_done;

`ifdef RW_PHASE_IRQ_EN
  logic   irq_pending;
`else
  logic   irq_inputs_unused;
  assign irq_inputs_unused = irq_req & irq_enable;
  assign irq_ack = 1'b0;
`endif

  assign wb_done = (state == WRITEBACK) && !stall_writeback;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (run) state_nxt = FETCH;
      FETCH:     if (!stall_fetch) state_nxt = DECODE;
      DECODE:    if (!stall_decode) state_nxt = EXECUTE;
      EXECUTE:   if (!stall_execute) state_nxt = MEMORY;
      MEMORY:    if (!stall_memory) state_nxt = WRITEBACK;
      WRITEBACK: begin
        if (!stall_writeback) begin
`ifdef RW_PHASE_IRQ_EN
          if (irq_pending)  state_nxt = TRAP;
          else if (run)     state_nxt = FETCH;
          else              state_nxt = IDLE;
`else
          state_nxt = run ? FETCH : IDLE;
`endif
        end
      end
`ifdef RW_PHASE_IRQ_EN
      TRAP:      state_nxt = run ? FETCH : IDLE;
`endif
      default:   state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      phase_fetch     <= 1'b0;
      phase_decode    <= 1'b0;
      phase_execute   <= 1'b0;
      phase_memory    <= 1'b0;
      phase_writeback <= 1'b0;
      busy            <= 1'b0;
      retire_count    <= '0;
`ifdef RW_PHASE_IRQ_EN
      irq_pending     <= 1'b0;
      irq_ack         <= 1'b0;
`endif
    end else begin
      state           <= state_nxt;
      phase_fetch     <= (state_nxt == FETCH);
      phase_decode    <= (state_nxt == DECODE);
      phase_execute   <= (state_nxt == EXECUTE);
      phase_memory    <= (state_nxt == MEMORY);
      phase_writeback <= (state_nxt == WRITEBACK);
      busy            <= (state_nxt != IDLE);
      if (wb_done)
        retire_count <= retire_count + {{(XLEN-1){1'b0}}, 1'b1};
`ifdef RW_PHASE_IRQ_EN
      irq_ack <= (state_nxt == TRAP);
      // A new request in the same cycle as trap exit must survive the clear.
      if (irq_req && irq_enable)
        irq_pending <= 1'b1;
      else if (state == TRAP)
        irq_pending <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: directed scenarios with literal expectations plus
// randomized stimulus compared every cycle against a phase-index reference model.
module tb_phase_sequencer;
  logic clk = 1'b0;
  logic reset, run, irq_req, irq_enable;
  logic stall_fetch, stall_decode, stall_execute, stall_memory, stall_writeback;
  logic phase_fetch, phase_decode, phase_execute, phase_memory, phase_writeback;
  logic irq_ack, busy;
  logic [31:0] retire_count;
  logic pf4, pd4, pe4, pm4, pw4, irq_ack4, busy4;
  logic [3:0] retire_count4;

  int n_checks = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  phase_sequencer #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .run(run),
    .stall_fetch(stall_fetch), .stall_decode(stall_decode), .stall_execute(stall_execute),
    .stall_memory(stall_memory), .stall_writeback(stall_writeback),
    .irq_req(irq_req), .irq_enable(irq_enable),
    .phase_fetch(phase_fetch), .phase_decode(phase_decode), .phase_execute(phase_execute),
    .phase_memory(phase_memory), .phase_writeback(phase_writeback),
    .irq_ack(irq_ack), .busy(busy), .retire_count(retire_count)
  );

  phase_sequencer #(.XLEN(4)) dut4 (
    .clk(clk), .reset(reset), .run(run),
    .stall_fetch(stall_fetch), .stall_decode(stall_decode), .stall_execute(stall_execute),
    .stall_memory(stall_memory), .stall_writeback(stall_writeback),
    .irq_req(irq_req), .irq_enable(irq_enable),
    .phase_fetch(pf4), .phase_decode(pd4), .phase_execute(pe4),
    .phase_memory(pm4), .phase_writeback(pw4),
    .irq_ack(irq_ack4), .busy(busy4), .retire_count(retire_count4)
  );

  logic [4:0] pv, pv4;
  assign pv  = {phase_fetch, phase_decode, phase_execute, phase_memory, phase_writeback};
  assign pv4 = {pf4, pd4, pe4, pm4, pw4};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: 0 = idle, 1..5 = fetch..writeback, 6 = trap.
  int m_ph = 0;
  bit m_pend = 1'b0;
  int unsigned m_cnt = 0;

  always @(posedge clk) begin
    logic [4:0] st;
    int nxt;
    st = {stall_writeback, stall_memory, stall_execute, stall_decode, stall_fetch};
    if (reset) begin
      m_ph = 0;
      m_pend = 1'b0;
      m_cnt = 0;
    end else begin
      nxt = m_ph;
      if (m_ph == 0) nxt = run ? 1 : 0;
      else if (m_ph >= 1 && m_ph <= 4) nxt = st[m_ph-1] ? m_ph : m_ph + 1;
      else if (m_ph == 5) begin
        if (!st[4]) begin
          m_cnt = m_cnt + 1;
`ifdef RW_PHASE_IRQ_EN
          nxt = m_pend ? 6 : (run ? 1 : 0);
`else
          nxt = run ? 1 : 0;
`endif
        end
      end else nxt = run ? 1 : 0;
`ifdef RW_PHASE_IRQ_EN
      if (irq_req && irq_enable) m_pend = 1'b1;
      else if (m_ph == 6) m_pend = 1'b0;
`endif
      m_ph = nxt;
    end
  end

  always @(negedge clk) begin
    logic [4:0] exp_pv;
    if (chk_en) begin
      exp_pv = (m_ph >= 1 && m_ph <= 5) ? (5'b10000 >> (m_ph - 1)) : 5'b00000;
      check("model_phases", {27'd0, pv}, {27'd0, exp_pv});
      check("model_phases_x4", {27'd0, pv4}, {27'd0, exp_pv});
      check("model_irq_ack", {31'd0, irq_ack}, {31'd0, (m_ph == 6)});
      check("model_busy", {31'd0, busy}, {31'd0, (m_ph != 0)});
      check("model_count", retire_count, m_cnt);
      check("model_count_x4", {28'd0, retire_count4}, {28'd0, m_cnt[3:0]});
    end
  end

  initial begin
    int ecount, acks;
    reset = 1'b1; run = 1'b0; irq_req = 1'b0; irq_enable = 1'b0;
    stall_fetch = 1'b0; stall_decode = 1'b0; stall_execute = 1'b0;
    stall_memory = 1'b0; stall_writeback = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_count", retire_count, 32'd0);
    check("reset_phases", {27'd0, pv}, 32'd0);
    check("reset_irq_ack", {31'd0, irq_ack}, 32'd0);

    // Unstalled stream: F,D,E,M,W repeating, three retired after 15 phase cycles.
    reset = 1'b0; run = 1'b1;
    step();
    for (int i = 0; i < 15; i++) begin
      check("stream_phase", {27'd0, pv}, {27'd0, 5'b10000 >> (i % 5)});
      step();
    end
    check("stream_count3", retire_count, 32'd3);
    check("stream_back_to_fetch", {31'd0, phase_fetch}, 32'd1);

    // Execute stall for 4 cycles with an ignored memory stall pulse.
    step(); step();
    check("at_execute", {31'd0, phase_execute}, 32'd1);
    ecount = 0;
    stall_execute = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (phase_execute) ecount++;
      stall_memory = (k == 0);
      step();
    end
    stall_execute = 1'b0;
    stall_memory = 1'b0;
    if (phase_execute) ecount++;
    step();
    check("execute_cycles", ecount, 32'd5);
    check("memory_after_stall", {31'd0, phase_memory}, 32'd1);
    step(); step();
    check("stall_count4", retire_count, 32'd4);

    // Interrupt pulsed during decode.
    step();
    check("at_decode", {31'd0, phase_decode}, 32'd1);
    irq_req = 1'b1; irq_enable = 1'b1;
    step();
    irq_req = 1'b0; irq_enable = 1'b0;
    step(); step(); step();
`ifdef RW_PHASE_IRQ_EN
    check("trap_ack", {31'd0, irq_ack}, 32'd1);
    check("trap_phases", {27'd0, pv}, 32'd0);
    check("trap_busy", {31'd0, busy}, 32'd1);
    check("trap_count5", retire_count, 32'd5);
    step();
`endif
    check("post_irq_fetch", {31'd0, phase_fetch}, 32'd1);
    check("post_irq_ack_low", {31'd0, irq_ack}, 32'd0);
    check("post_irq_count5", retire_count, 32'd5);

    // Drop run during memory, then masked irq while idle.
    step(); step(); step();
    check("at_memory", {31'd0, phase_memory}, 32'd1);
    run = 1'b0;
    step(); step();
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_phases", {27'd0, pv}, 32'd0);
    check("idle_count6", retire_count, 32'd6);
    irq_req = 1'b1; irq_enable = 1'b0;
    step();
    irq_req = 1'b0;
    step();
    check("idle_stays", {31'd0, busy}, 32'd0);
    run = 1'b1;
    step();
    check("rerun_fetch", {31'd0, phase_fetch}, 32'd1);
    step(); step(); step(); step(); step();
    check("no_trap_fetch", {31'd0, phase_fetch}, 32'd1);
    check("no_trap_ack", {31'd0, irq_ack}, 32'd0);
    check("count7", retire_count, 32'd7);

    // Reset while writeback is stalled.
    step(); step(); step(); step();
    stall_writeback = 1'b1;
    step();
    check("wb_held", {31'd0, phase_writeback}, 32'd1);
    check("wb_held_count", retire_count, 32'd7);
    reset = 1'b1;
    step();
    check("wb_reset_busy", {31'd0, busy}, 32'd0);
    check("wb_reset_count", retire_count, 32'd0);
    check("wb_reset_count_x4", {28'd0, retire_count4}, 32'd0);
    check("wb_reset_phases", {27'd0, pv}, 32'd0);
    reset = 1'b0; stall_writeback = 1'b0;
    step();
    check("post_reset_fetch", {31'd0, phase_fetch}, 32'd1);

    // Sixteen instructions wrap the 4-bit counter.
    for (int i = 0; i < 80; i++) step();
    check("wrap_count32", retire_count, 32'd16);
    check("wrap_count4", {28'd0, retire_count4}, 32'd0);

`ifndef RW_PHASE_IRQ_EN
    irq_req = 1'b1; irq_enable = 1'b1;
    acks = 0;
    for (int i = 0; i < 25; i++) begin
      if (irq_ack) acks++;
      step();
    end
    irq_req = 1'b0; irq_enable = 1'b0;
    check("noirq_acks", acks, 32'd0);
    check("noirq_count", retire_count, 32'd21);
`else
    acks = 0;
`endif

    // Randomized traffic, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      run             = ($urandom_range(0, 9) < 8);
      stall_fetch     = ($urandom_range(0, 3) == 0);
      stall_decode    = ($urandom_range(0, 3) == 0);
      stall_execute   = ($urandom_range(0, 3) == 0);
      stall_memory    = ($urandom_range(0, 3) == 0);
      stall_writeback = ($urandom_range(0, 3) == 0);
      irq_req         = ($urandom_range(0, 9) == 0);
      irq_enable      = ($urandom_range(0, 1) == 1);
      reset           = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;
    step();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 Parameter XLEN, default 32, width of the retired-instruction counter.
REQ-002 clk  input  1  single core clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 run  input  1  1 = fetch new instructions; 0 = finish the current instruction, then idle.
REQ-005 stall_fetch, stall_decode, stall_execute, stall_memory, stall_writeback  input  1 each  hold request from the matching phase block.
REQ-006 irq_req  input  1  level interrupt request.
REQ-007 irq_enable  input  1  interrupt acceptance gate (from CSR).
REQ-008 phase_fetch, phase_decode, phase_execute, phase_memory, phase_writeback  output  1 each  active-phase strobes, at most one high.
REQ-009 irq_ack  output  1  one-cycle trap-entry pulse.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 retire_count  output  XLEN  count of completed writeback phases.

Function
REQ-012 States SHALL be IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP, held in a state register.
REQ-013 All outputs SHALL be decoded from registers only, with no combinational path from inputs to outputs.
REQ-014 phase_x SHALL equal 1 exactly while in state x; all phase strobes SHALL be 0 in IDLE and TRAP.
REQ-015 IDLE SHALL go to FETCH on the cycle after run=1 is sampled; otherwise it stays in IDLE.
REQ-016 In FETCH..MEMORY, the state SHALL hold while its own stall_x=1, and advance to the next phase in order on the first cycle stall_x=0, giving 1-cycle-per-phase latency with no stalls.
REQ-017 Stall inputs of non-active phases SHALL be ignored.
REQ-018 WRITEBACK with stall_writeback=0 SHALL complete the instruction.
  - Next state is TRAP if irq_pending=1.
  - Else FETCH if run=1.
  - Else IDLE.
REQ-019 A completed WRITEBACK SHALL increment retire_count by 1 on the same edge, wrapping from all-ones to 0.
REQ-020 irq_pending SHALL be set on any cycle with irq_req=1 and irq_enable=1, and cleared on the edge leaving TRAP.
  - Set has priority over clear on the same cycle.
REQ-021 TRAP SHALL last exactly one cycle with irq_ack=1, then go to FETCH if run=1, else IDLE.
REQ-022 An irq arriving mid-instruction SHALL NOT abort it; it is taken only at WRITEBACK completion.
REQ-023 Deasserting run mid-instruction SHALL let the instruction finish through WRITEBACK (and TRAP if pending) before entering IDLE.
REQ-024 busy SHALL be 0 only in IDLE.

Reset
REQ-025 reset=1 SHALL on the next edge force:
  - state=IDLE, irq_pending=0, retire_count=0;
  - all phase strobes=0, irq_ack=0, busy=0;
  - and SHALL override all other inputs, including reset asserted mid-phase or in TRAP.
REQ-026 After reset deasserts, the first FETCH SHALL occur no earlier than the cycle after run=1 is sampled.

Configuration
REQ-027 Macro RW_PHASE_IRQ_EN defined: TRAP state, irq_pending and irq_ack SHALL be implemented per REQ-018/020/021/022.
REQ-028 Macro RW_PHASE_IRQ_EN undefined: TRAP and irq_pending SHALL be removed.
  - irq_ack is tied to 0; irq_req and irq_enable are ignored.
  - WRITEBACK completion goes to FETCH (run=1) or IDLE (run=0).

Verification
REQ-029 Reset, run=1, all stalls=0 -> strobes visit F,D,E,M,W once per cycle, repeating every 5 cycles; retire_count=3 after 15 phase cycles.
REQ-030 stall_execute=1 for 4 cycles during EXECUTE, plus a pulse on stall_memory during EXECUTE -> phase_execute high for 5 cycles; the stall_memory pulse has no effect; retire_count +1 after WRITEBACK.
REQ-031 irq_req=1, irq_enable=1 pulsed 1 cycle during DECODE (macro defined) -> instruction completes, one TRAP cycle with irq_ack=1, then FETCH; irq_req pulsed during IDLE with irq_enable=0 -> no TRAP.
REQ-032 run dropped during MEMORY -> WRITEBACK completes, then IDLE with busy=0; run reasserted -> FETCH next cycle.
REQ-033 retire_count preset by XLEN=4 build, 16 instructions -> wraps to 0; reset asserted during WRITEBACK with stall_writeback=1 -> IDLE, retire_count=0, no increment.
REQ-034 Macro undefined, irq_req=irq_enable=1 held -> irq_ack never asserts; WRITEBACK always proceeds to FETCH.
